// File: rtl/multicycle_controller.sv
// multicycle_controller
//
// Multi-cycle main controller. Each instruction walks FETCH -> DECODE -> EXEC
// -> (MEM) -> (WB) under a registered state. All outputs are decoded
// combinationally from the current state and the IR opcode; only the state,
// the sticky illegal flag and the retired-instruction counter are registers.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-low reset
//   opcode      IR[6:0], valid from DECODE onward
//   imem_ready  instruction word available this cycle
//   dmem_ready  data access completes this cycle (only looked at if MEM_WAIT)
//   stall       freeze the FSM and suppress ir/pc/reg write and retire strobes
//   imem_req    instruction fetch request (FETCH)
//   ir_write    load IR, 1-cycle strobe
//   pc_write    update PC, 1-cycle strobe
//   alu_src     0: rs2, 1: immediate
//   alu_op      00 add, 01 branch compare, 10 funct decode
//   wb_sel      00 ALU, 01 memory, 10 PC+4, 11 immediate
//   reg_write   register file write strobe
//   mem_read    data memory read enable
//   mem_write   data memory write enable
//   branch      PC select from branch comparison
//   jump        PC select jump target
//   illegal     sticky illegal-opcode flag
//   retire      1-cycle pulse when an instruction completes
//   instret     retired-instruction count, wraps
//   state       current state encoding (debug)

module multicycle_controller #(
  parameter int OPCODE_W    = 7,
  parameter int CNT_W       = 32,
  parameter bit ENABLE_JUMP = 1'b1,
  parameter bit MEM_WAIT    = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  input  logic                stall,
  output logic                imem_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic                alu_src,
  output logic [1:0]          alu_op,
  output logic [1:0]          wb_sel,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                branch,
  output logic                jump,
  output logic                illegal,
  output logic                retire,
  output logic [CNT_W-1:0]    instret,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_I    = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_BR   = OPCODE_W'(7'b1100011);
  localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(7'b1101111);
  localparam logic [OPCODE_W-1:0] OP_JALR = OPCODE_W'(7'b1100111);
  localparam logic [OPCODE_W-1:0] OP_LUI  = OPCODE_W'(7'b0110111);

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] instret_q;

  // Opcode class decode; jump-family opcodes vanish when ENABLE_JUMP is 0,
  // which makes them fall through to the illegal path in DECODE.
  logic is_r, is_i, is_lw, is_sw, is_br, is_jal, is_jalr, is_lui, is_legal;

  always_comb begin
    is_r     = (opcode == OP_R);
    is_i     = (opcode == OP_I);
    is_lw    = (opcode == OP_LW);
    is_sw    = (opcode == OP_SW);
    is_br    = (opcode == OP_BR);
    is_jal   = ENABLE_JUMP && (opcode == OP_JAL);
    is_jalr  = ENABLE_JUMP && (opcode == OP_JALR);
    is_lui   = ENABLE_JUMP && (opcode == OP_LUI);
    is_legal = is_r | is_i | is_lw | is_sw | is_br | is_jal | is_jalr | is_lui;
  end

  // A data access completes on dmem_ready, or unconditionally after one
  // cycle when the memory is known to be single-cycle.
  logic mem_done;
  assign mem_done = MEM_WAIT ? dmem_ready : 1'b1;

  // Raw (pre-reset-gating) output values.
  logic       imem_req_c, ir_write_c, pc_write_c, alu_src_c;
  logic [1:0] alu_op_c, wb_sel_c;
  logic       reg_write_c, mem_read_c, mem_write_c, branch_c, jump_c, retire_c;

  always_comb begin
    // NOTE: every signal assigned in this block gets a default here, so no
    // path through the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    illegal_d   = illegal_q;
    imem_req_c  = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    alu_src_c   = 1'b0;
    alu_op_c    = 2'b00;
    wb_sel_c    = 2'b00;
    reg_write_c = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    branch_c    = 1'b0;
    jump_c      = 1'b0;
    retire_c    = 1'b0;

    // Selects and enables follow the state alone; strobes and transitions
    // additionally require !stall, so a ready seen during a stall is dropped.
    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready && !stall) begin
          ir_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end

      S_DECODE: begin
        if (!stall) begin
          if (is_legal) begin
            state_d = S_EXEC;
          end else begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        end
      end

      S_EXEC: begin
        alu_src_c = is_i | is_lw | is_sw | is_jalr;
        if (is_r || is_i)  alu_op_c = 2'b10;
        else if (is_br)    alu_op_c = 2'b01;
        else               alu_op_c = 2'b00;
        branch_c = is_br;
        if (!stall) begin
          if (is_br) begin
            pc_write_c = 1'b1;
            retire_c   = 1'b1;
            state_d    = S_FETCH;
          end else if (is_lw || is_sw) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_MEM: begin
        mem_read_c  = is_lw;
        mem_write_c = is_sw;
        if (mem_done && !stall) begin
          if (is_sw) begin
            pc_write_c = 1'b1;
            retire_c   = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        if (is_lw)                 wb_sel_c = 2'b01;
        else if (is_jal || is_jalr) wb_sel_c = 2'b10;
        else if (is_lui)           wb_sel_c = 2'b11;
        else                       wb_sel_c = 2'b00;
        jump_c = is_jal | is_jalr;
        if (!stall) begin
          reg_write_c = 1'b1;
          pc_write_c  = 1'b1;
          retire_c    = 1'b1;
          state_d     = S_FETCH;
        end
      end

      // Terminal until reset; the sticky flag is the only visible output.
      S_TRAP: state_d = S_TRAP;

      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only; just the three control
    // registers need a known value, everything else is decoded from them.
    if (!reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before the edge, independent of statement order.
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (retire_c) instret_q <= instret_q + CNT_W'(1);
    end
  end

  // While reset is held low every output except the debug state reads 0, so
  // an aborted instruction cannot leak a strobe in the reset cycle.
  assign imem_req  = reset & imem_req_c;
  assign ir_write  = reset & ir_write_c;
  assign pc_write  = reset & pc_write_c;
  assign alu_src   = reset & alu_src_c;
  assign alu_op    = reset ? alu_op_c : 2'b00;
  assign wb_sel    = reset ? wb_sel_c : 2'b00;
  assign reg_write = reset & reg_write_c;
  assign mem_read  = reset & mem_read_c;
  assign mem_write = reset & mem_write_c;
  assign branch    = reset & branch_c;
  assign jump      = reset & jump_c;
  assign illegal   = reset & illegal_q;
  assign retire    = reset & retire_c;
  assign instret   = reset ? instret_q : '0;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller. Two instances share one stimulus:
//   A: defaults (CNT_W=32, ENABLE_JUMP=1, MEM_WAIT=1)
//   B: CNT_W=4, ENABLE_JUMP=0, MEM_WAIT=0
// Each instance has a reference model that walks a per-opcode route of
// phases; a compare process checks every output on every negative edge,
// and the directed sequence adds hand-computed literal expectations.

module tb_multicycle_controller;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  typedef enum int {K_R, K_I, K_LW, K_SW, K_BR, K_JAL, K_JALR, K_LUI, K_BAD} kind_t;

  typedef struct packed {
    logic        imem_req;
    logic        ir_write;
    logic        pc_write;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic [1:0]  wb_sel;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
    logic        retire;
    logic [31:0] instret;
    logic [2:0]  state;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset, imem_ready, dmem_ready, stall;
  logic [6:0] opcode;

  logic        a_imem_req, a_ir_write, a_pc_write, a_alu_src, a_reg_write;
  logic        a_mem_read, a_mem_write, a_branch, a_jump, a_illegal, a_retire;
  logic [1:0]  a_alu_op, a_wb_sel;
  logic [31:0] a_instret;
  logic [2:0]  a_state;

  logic        b_imem_req, b_ir_write, b_pc_write, b_alu_src, b_reg_write;
  logic        b_mem_read, b_mem_write, b_branch, b_jump, b_illegal, b_retire;
  logic [1:0]  b_alu_op, b_wb_sel;
  logic [3:0]  b_instret;
  logic [2:0]  b_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_controller dut_a (
    .clk(clk), .reset(reset), .opcode(opcode), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .stall(stall), .imem_req(a_imem_req),
    .ir_write(a_ir_write), .pc_write(a_pc_write), .alu_src(a_alu_src),
    .alu_op(a_alu_op), .wb_sel(a_wb_sel), .reg_write(a_reg_write),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .branch(a_branch),
    .jump(a_jump), .illegal(a_illegal), .retire(a_retire),
    .instret(a_instret), .state(a_state)
  );

  multicycle_controller #(.CNT_W(4), .ENABLE_JUMP(1'b0), .MEM_WAIT(1'b0)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .stall(stall), .imem_req(b_imem_req),
    .ir_write(b_ir_write), .pc_write(b_pc_write), .alu_src(b_alu_src),
    .alu_op(b_alu_op), .wb_sel(b_wb_sel), .reg_write(b_reg_write),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .branch(b_branch),
    .jump(b_jump), .illegal(b_illegal), .retire(b_retire),
    .instret(b_instret), .state(b_state)
  );

  obs_t act_a, act_b;
  assign act_a = {a_imem_req, a_ir_write, a_pc_write, a_alu_src, a_alu_op, a_wb_sel,
                  a_reg_write, a_mem_read, a_mem_write, a_branch, a_jump, a_illegal,
                  a_retire, a_instret, a_state};
  assign act_b = {b_imem_req, b_ir_write, b_pc_write, b_alu_src, b_alu_op, b_wb_sel,
                  b_reg_write, b_mem_read, b_mem_write, b_branch, b_jump, b_illegal,
                  b_retire, 28'd0, b_instret, b_state};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h @%0t", name, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // An instruction is a route of phases (0 F,1 D,2 E,3 M,4 W,5 T); the model
  // keeps a step index into the route and a count of retired instructions.
  int    m_step [2] = '{0, 0};
  kind_t m_kind [2] = '{K_R, K_R};
  bit    m_ill  [2] = '{1'b0, 1'b0};
  int    m_ret  [2] = '{0, 0};
  bit    m_valid = 1'b0;

  function automatic bit en_jump(input int i);  return i == 0; endfunction
  function automatic bit mem_wait(input int i); return i == 0; endfunction
  function automatic logic [31:0] cnt_mask(input int i);
    return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
  endfunction

  function automatic kind_t classify(input logic [6:0] op, input bit jmp);
    case (op)
      OP_R:    return K_R;
      OP_I:    return K_I;
      OP_LW:   return K_LW;
      OP_SW:   return K_SW;
      OP_BR:   return K_BR;
      OP_JAL:  return jmp ? K_JAL  : K_BAD;
      OP_JALR: return jmp ? K_JALR : K_BAD;
      OP_LUI:  return jmp ? K_LUI  : K_BAD;
      default: return K_BAD;
    endcase
  endfunction

  // Latency table: BR 3, LW 5, everything else 4; illegal stops in TRAP.
  function automatic int route_len(input kind_t k);
    case (k)
      K_BR:    return 3;
      K_LW:    return 5;
      K_BAD:   return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int phase_at(input kind_t k, input int step);
    if (step < 2)   return step;
    if (k == K_BAD) return 5;
    if (step == 2)  return 2;
    if (step == 3)  return (k == K_LW || k == K_SW) ? 3 : 4;
    return 4;
  endfunction

  function automatic int phase_now(input int i);
    return phase_at(m_kind[i], m_step[i]);
  endfunction

  function automatic bit model_go(input int i);
    case (phase_now(i))
      0:       return imem_ready && !stall;
      1, 2, 4: return !stall;
      3:       return !stall && (!mem_wait(i) || dmem_ready);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit model_last(input int i);
    return m_step[i] >= 2 && m_kind[i] != K_BAD && m_step[i] == route_len(m_kind[i]) - 1;
  endfunction

  function automatic obs_t expect_out(input int i);
    obs_t  e;
    int    ph;
    kind_t k;
    bit    ret;
    e       = '0;
    ph      = phase_now(i);
    k       = m_kind[i];
    e.state = 3'(ph);
    if (!reset) return e;
    ret         = model_go(i) && model_last(i);
    e.imem_req  = (ph == 0);
    e.ir_write  = (ph == 0) && model_go(i);
    e.alu_src   = (ph == 2) && (k inside {K_I, K_LW, K_SW, K_JALR});
    if (ph == 2) e.alu_op = (k inside {K_R, K_I}) ? 2'b10 : (k == K_BR) ? 2'b01 : 2'b00;
    e.branch    = (ph == 2) && (k == K_BR);
    e.mem_read  = (ph == 3) && (k == K_LW);
    e.mem_write = (ph == 3) && (k == K_SW);
    if (ph == 4) e.wb_sel = (k == K_LW) ? 2'b01 : (k == K_JAL || k == K_JALR) ? 2'b10 :
                            (k == K_LUI) ? 2'b11 : 2'b00;
    e.jump      = (ph == 4) && (k == K_JAL || k == K_JALR);
    e.reg_write = (ph == 4) && model_go(i);
    e.pc_write  = ret;
    e.retire    = ret;
    e.illegal   = m_ill[i];
    e.instret   = 32'(m_ret[i]) & cnt_mask(i);
    return e;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_step[i] <= 0;
        m_ill[i]  <= 1'b0;
        m_ret[i]  <= 0;
      end else if (model_go(i)) begin
        if (model_last(i)) begin
          m_step[i] <= 0;
          m_ret[i]  <= m_ret[i] + 1;
        end else begin
          if (m_step[i] == 1) begin
            m_kind[i] <= classify(opcode, en_jump(i));
            if (classify(opcode, en_jump(i)) == K_BAD) m_ill[i] <= 1'b1;
          end
          m_step[i] <= m_step[i] + 1;
        end
      end
    end
    if (!reset) m_valid <= 1'b1;
  end

  task automatic compare_obs(input string n, input obs_t g, input obs_t w);
    check({n, ".imem_req"},  32'(g.imem_req),  32'(w.imem_req));
    check({n, ".ir_write"},  32'(g.ir_write),  32'(w.ir_write));
    check({n, ".pc_write"},  32'(g.pc_write),  32'(w.pc_write));
    check({n, ".alu_src"},   32'(g.alu_src),   32'(w.alu_src));
    check({n, ".alu_op"},    32'(g.alu_op),    32'(w.alu_op));
    check({n, ".wb_sel"},    32'(g.wb_sel),    32'(w.wb_sel));
    check({n, ".reg_write"}, 32'(g.reg_write), 32'(w.reg_write));
    check({n, ".mem_read"},  32'(g.mem_read),  32'(w.mem_read));
    check({n, ".mem_write"}, 32'(g.mem_write), 32'(w.mem_write));
    check({n, ".branch"},    32'(g.branch),    32'(w.branch));
    check({n, ".jump"},      32'(g.jump),      32'(w.jump));
    check({n, ".illegal"},   32'(g.illegal),   32'(w.illegal));
    check({n, ".retire"},    32'(g.retire),    32'(w.retire));
    check({n, ".instret"},   g.instret,        w.instret);
    check({n, ".state"},     32'(g.state),     32'(w.state));
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      compare_obs("model_A", act_a, expect_out(0));
      compare_obs("model_B", act_b, expect_out(1));
    end
  end

  // ---------------- directed sequence ----------------
  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic mid(); @(negedge clk); endtask

  task automatic wait_idle();
    int n = 0;
    imem_ready = 1'b0; dmem_ready = 1'b1; stall = 1'b0;
    while (!(m_step[0] == 0 && (m_step[1] == 0 || m_ill[1])) && n < 20) begin
      cyc(); n++;
    end
    check("idle_timeout", 32'(n < 20), 32'd1);
    dmem_ready = 1'b0;
  endtask

  task automatic run_instr(input logic [6:0] op);
    int n = 0;
    opcode = op; imem_ready = 1'b1; dmem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0;
    while (m_step[0] != 0 && n < 12) begin
      cyc(); n++;
    end
    check("instr_timeout", 32'(n < 12), 32'd1);
    dmem_ready = 1'b0;
  endtask

  int r_states [5] = '{0, 1, 2, 4, 0};
  int r_rw     [5] = '{0, 0, 0, 1, 0};

  initial begin
    int n_rd, n_ret, n_wr, n_rw;
    reset = 1'b0; opcode = OP_R; imem_ready = 1'b0; dmem_ready = 1'b0; stall = 1'b0;

    // Reset held for two cycles: outputs forced low.
    repeat (2) begin
      mid();
      check("rst_imem_req", 32'(a_imem_req), 32'd0);
      check("rst_instret", a_instret, 32'd0);
      cyc();
    end

    // R-type: states 0,1,2,4,0; reg_write only in WB; instret becomes 1.
    reset = 1'b1; imem_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      mid();
      check($sformatf("r_state_a[%0d]", c), 32'(a_state), 32'(r_states[c]));
      check($sformatf("r_state_b[%0d]", c), 32'(b_state), 32'(r_states[c]));
      check($sformatf("r_regw_a[%0d]", c), 32'(a_reg_write), 32'(r_rw[c]));
      if (c == 3) check("r_wb_sel", 32'(a_wb_sel), 32'd0);
      if (c == 4) begin
        check("r_instret_a", a_instret, 32'd1);
        check("r_instret_b", 32'(b_instret), 32'd1);
      end
      cyc();
      imem_ready = 1'b0;
    end

    // LW on A with dmem_ready low for 3 MEM cycles: 8 cycles total.
    opcode = OP_LW; n_rd = 0; n_ret = 0;
    for (int c = 1; c <= 9; c++) begin
      imem_ready = (c == 1); dmem_ready = (c == 7);
      mid();
      n_rd  += int'(a_mem_read);
      n_ret += int'(a_retire);
      if (c == 7) check("lw_state_mem", 32'(a_state), 32'd3);
      if (c == 8) begin
        check("lw_wb_sel", 32'(a_wb_sel), 32'd1);
        check("lw_reg_write", 32'(a_reg_write), 32'd1);
      end
      if (c == 9) begin
        check("lw_back_fetch", 32'(a_state), 32'd0);
        check("lw_instret", a_instret, 32'd2);
      end
      cyc();
    end
    check("lw_mem_read_cycles", 32'(n_rd), 32'd4);
    check("lw_retire_count", 32'(n_ret), 32'd1);

    // SW on B (single-cycle MEM), dmem_ready held low.
    opcode = OP_SW; dmem_ready = 1'b0; n_wr = 0; n_rw = 0;
    for (int c = 1; c <= 6; c++) begin
      imem_ready = (c == 1);
      mid();
      n_wr += int'(b_mem_write);
      n_rw += int'(b_reg_write);
      if (c == 4) begin
        check("sw_state_mem", 32'(b_state), 32'd3);
        check("sw_pc_write", 32'(b_pc_write), 32'd1);
        check("sw_retire", 32'(b_retire), 32'd1);
      end
      if (c == 5) check("sw_back_fetch", 32'(b_state), 32'd0);
      cyc();
    end
    check("sw_mem_write_cycles", 32'(n_wr), 32'd1);
    check("sw_reg_write_count", 32'(n_rw), 32'd0);
    wait_idle();

    // BR: 3-cycle instruction, strobes in EXEC, no WB.
    opcode = OP_BR; n_rw = 0;
    for (int c = 1; c <= 4; c++) begin
      imem_ready = (c == 1);
      mid();
      n_rw += int'(a_reg_write) + int'(b_reg_write);
      if (c == 3) begin
        check("br_branch", 32'(a_branch), 32'd1);
        check("br_alu_op", 32'(a_alu_op), 32'd1);
        check("br_pc_write", 32'(a_pc_write), 32'd1);
        check("br_branch_b", 32'(b_branch), 32'd1);
      end
      if (c == 4) begin
        check("br_fetch_a", 32'(a_state), 32'd0);
        check("br_fetch_b", 32'(b_state), 32'd0);
      end
      cyc();
    end
    check("br_no_reg_write", 32'(n_rw), 32'd0);

    // JAL: legal on A (jump, PC+4 writeback), traps on B for good.
    opcode = OP_JAL;
    for (int c = 1; c <= 13; c++) begin
      imem_ready = (c == 1);
      mid();
      if (c == 4) begin
        check("jal_jump", 32'(a_jump), 32'd1);
        check("jal_wb_sel", 32'(a_wb_sel), 32'd2);
      end
      if (c >= 3 && c <= 12) begin
        check($sformatf("trap_illegal[%0d]", c), 32'(b_illegal), 32'd1);
        check($sformatf("trap_instret[%0d]", c), 32'(b_instret), 32'd4);
        check($sformatf("trap_state[%0d]", c), 32'(b_state), 32'd5);
      end
      cyc();
    end
    run_instr(OP_I);
    run_instr(OP_JALR);
    run_instr(OP_LUI);
    mid();
    check("jump_group_instret", a_instret, 32'd8);
    cyc();

    // Illegal opcode on A as well.
    opcode = OP_BAD; imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0;
    cyc();
    mid();
    check("bad_illegal_a", 32'(a_illegal), 32'd1);
    check("bad_state_a", 32'(a_state), 32'd5);
    cyc();

    // Reset clears the trap on both instances.
    reset = 1'b0;
    mid();
    check("rst_trap_illegal_forced", 32'(a_illegal), 32'd0);
    check("rst_trap_instret_forced", a_instret, 32'd0);
    cyc();
    reset = 1'b1;
    mid();
    check("rst_state_a", 32'(a_state), 32'd0);
    check("rst_state_b", 32'(b_state), 32'd0);
    check("rst_illegal_b", 32'(b_illegal), 32'd0);
    cyc();

    // Reset during WB aborts the instruction without strobes.
    opcode = OP_R;
    for (int c = 1; c <= 4; c++) begin
      imem_ready = (c == 1);
      if (c == 4) reset = 1'b0;
      mid();
      if (c == 4) begin
        check("abort_reg_write", 32'(a_reg_write), 32'd0);
        check("abort_retire", 32'(a_retire), 32'd0);
        check("abort_pc_write", 32'(a_pc_write), 32'd0);
        check("abort_state", 32'(a_state), 32'd4);
      end
      cyc();
    end
    reset = 1'b1;
    mid();
    check("abort_state_after", 32'(a_state), 32'd0);
    check("abort_instret_a", a_instret, 32'd0);
    check("abort_instret_b", 32'(b_instret), 32'd0);
    cyc();

    // 16 back-to-back R-types: B's 4-bit counter wraps 15 -> 0. Stall in
    // WB of instruction 2 and in FETCH of instruction 5.
    opcode = OP_R;
    for (int n = 0; n < 16; n++) begin
      imem_ready = 1'b1;
      if (n == 5) begin
        stall = 1'b1;
        mid();
        check("stall_f_ir_write", 32'(a_ir_write), 32'd0);
        check("stall_f_imem_req", 32'(a_imem_req), 32'd1);
        cyc();
        stall = 1'b0;
      end
      mid(); cyc();
      imem_ready = 1'b0;
      mid(); cyc();
      mid(); cyc();
      if (n == 2) begin
        stall = 1'b1;
        repeat (2) begin
          mid();
          check("stall_wb_reg_write", 32'(a_reg_write), 32'd0);
          check("stall_wb_state", 32'(a_state), 32'd4);
          check("stall_wb_retire_b", 32'(b_retire), 32'd0);
          cyc();
        end
        stall = 1'b0;
      end
      mid();
      check($sformatf("wrap_reg_write[%0d]", n), 32'(a_reg_write), 32'd1);
      check($sformatf("wrap_instret_a[%0d]", n), a_instret, 32'(n));
      check($sformatf("wrap_instret_b[%0d]", n), 32'(b_instret), 32'(n % 16));
      cyc();
    end
    mid();
    check("wrap_final_a", a_instret, 32'd16);
    check("wrap_final_b", 32'(b_instret), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle successor to the single-cycle main decoder. FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB using a registered state instead of decoding in one cycle. Adds instruction/data memory ready handshakes, a global stall, JAL/JALR/LUI support, illegal-opcode trapping and a retired-instruction counter. Sits between the IR opcode field and the datapath muxes, register file, PC and memory enables.

Parameters:
OPCODE_W, 7, opcode field width
CNT_W, 32, width of instret counter
ENABLE_JUMP, 1, 1: JAL(1101111)/JALR(1100111)/LUI(0110111) legal; 0: treated as illegal
MEM_WAIT, 1, 1: MEM state waits for dmem_ready; 0: MEM always lasts exactly 1 cycle

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
opcode  in  OPCODE_W  IR[6:0]; valid from DECODE onward
imem_ready  in  1  instruction word available this cycle
dmem_ready  in  1  data access completes this cycle
stall  in  1  freeze FSM and suppress strobes
imem_req  out  1  instruction fetch request
ir_write  out  1  load IR (1-cycle strobe)
pc_write  out  1  update PC (1-cycle strobe)
alu_src  out  1  0: rs2; 1: immediate
alu_op  out  2  00 add (LW/SW/JALR/LUI), 01 branch compare, 10 R/I-type funct decode
wb_sel  out  2  00 ALU, 01 memory, 10 PC+4, 11 immediate
reg_write  out  1  register file write strobe
mem_read  out  1  data memory read enable
mem_write  out  1  data memory write enable
branch  out  1  PC select from branch comparison
jump  out  1  PC select jump target (JAL: PC+imm, JALR: ALU)
illegal  out  1  sticky illegal-opcode flag
retire  out  1  1-cycle pulse, instruction completed
instret  out  CNT_W  count of retired instructions
state  out  3  current state encoding (debug)

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; 6,7 unreachable -> FETCH next cycle.
- Reset (reset==0 at clk edge): state=FETCH, illegal=0, instret=0. While reset is low, all outputs except state are forced to 0.
- Outputs are combinational from the registered state and the opcode; no output registers.
- FETCH: imem_req=1. When imem_ready: ir_write=1, next=DECODE. Otherwise hold.
- DECODE: legal opcodes are R(0110011), I(0010011), LW(0000011), SW(0100011), BR(1100011), plus JAL/JALR/LUI when ENABLE_JUMP=1. Legal -> EXEC. Illegal -> TRAP.
- EXEC:
  - alu_src=1 for I/LW/SW/JALR; 0 otherwise.
  - alu_op is set per the table in Ports.
  - LW/SW -> MEM.
  - BR: branch=1, pc_write=1, retire=1, next FETCH.
  - All other legal opcodes -> WB.
- MEM: mem_read=1 (LW) or mem_write=1 (SW), held until dmem_ready (ignored if MEM_WAIT=0).
  - On completion, LW -> WB.
  - SW: pc_write=1, retire=1, next FETCH.
- WB: reg_write=1, pc_write=1, retire=1, next FETCH.
  - wb_sel: R/I=00, LW=01, JAL/JALR=10, LUI=11.
  - jump=1 for JAL/JALR.
- TRAP: illegal=1, all other strobes 0. Stays in TRAP until reset.
- stall=1:
  - State holds.
  - ir_write, pc_write, reg_write and retire are forced to 0.
  - imem_req, mem_read, mem_write and the mux selects keep their state values.
  - A simultaneous ready is ignored; the requester must re-present it.
- instret increments by 1 on each retire. It wraps from 2^CNT_W-1 to 0.
- Latency in cycles, assuming no stall and ready on the first cycle:
  - BR = 3
  - R/I/LUI/JAL/JALR = 4
  - SW = 4
  - LW = 5
- Reset asserted mid-instruction aborts it. No retire is produced and no strobe is emitted in that cycle.

Test Plan:
- Reset low 2 cycles, then high, imem_ready=1, opcode=0110011 -> state 0,1,2,4,0. reg_write=1 and wb_sel=00 only in cycle 4. instret=1.
- LW (0000011), imem_ready=1, dmem_ready low 3 cycles then high -> mem_read=1 for 4 cycles, then WB with wb_sel=01. Total 8 cycles. retire=1 once.
- SW (0100011) with MEM_WAIT=0, dmem_ready=0 -> mem_write=1 for exactly 1 cycle. pc_write=1 and retire=1 in MEM. Back to FETCH. reg_write never 1.
- BR (1100011) -> branch=1, alu_op=01, pc_write=1 in EXEC. 3-cycle instruction. No WB cycle.
- ENABLE_JUMP=0, opcode=1101111 -> DECODE -> TRAP. illegal=1 held for 10 cycles, instret unchanged. reset low clears illegal=0, state=0.
- CNT_W=4, 16 back-to-back R-type instructions -> instret wraps 15 to 0. stall=1 asserted during a WB cycle -> reg_write=0 and state holds; the strobe appears the cycle after stall drops.
